alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequencer for an external 4-bit ALU: it decodes an instruction, reads the register file and captures the ALU result.
// The optional macro ALU_SEQ_DIV0_TRAP_EN makes a divide by a zero register trap as an illegal instruction.
module alu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  output logic [3:0]  alu_x,
  output logic [3:0]  alu_y,
  output logic [3:0]  alu_op,
  input  logic [3:0]  alu_o,
  input  logic [7:0]  alu_product,
  input  logic [3:0]  alu_remainder,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [3:0]  out_rem,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, OUT} state_t;

  typedef enum logic [3:0] {
    OP_NOT   = 4'd0,
    OP_AND   = 4'd1,
    OP_NAND  = 4'd2,
    OP_OR    = 4'd3,
    OP_NOR   = 4'd4,
    OP_XOR   = 4'd5,
    OP_XNOR  = 4'd6,
    OP_SHIFT = 4'd7,
    OP_ADD   = 4'd8,
    OP_SUB   = 4'd9,
    OP_MUL   = 4'd10,
    OP_DIV   = 4'd11,
    OP_LOADI = 4'd12
  } opcode_e;

`ifdef ALU_SEQ_DIV0_TRAP_EN
  localparam bit DIV0_TRAP = 1'b1;
`else
  localparam bit DIV0_TRAP = 1'b0;
`endif

  state_t      state, state_nxt;
  logic        accept;
  logic [3:0]  f_op, f_imm;
  logic [1:0]  f_rd, f_rs, f_rt;
  logic        reserved_unused;

  logic [3:0]  rf [4];
  logic [1:0]  rd_q;
  logic [3:0]  imm_q;

  logic [7:0]  cap_data;
  logic [3:0]  cap_rem;
  logic        cap_err;
  logic        cap_we;
  logic [3:0]  cap_wdata;

  assign f_op            = in_instr[15:12];
  assign f_rd            = in_instr[11:10];
  assign f_rs            = in_instr[9:8];
  assign f_rt            = in_instr[7:6];
  assign f_imm           = in_instr[3:0];
  assign reserved_unused = ^in_instr[5:4];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned and a latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ISSUE;
      ISSUE:                  state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  assign accept = in_valid && in_ready;

  // ---------------- result capture ----------------
  // Illegal is the default, so opcodes 13-15 and a trapped divide share one path.
  always_comb begin
    cap_data  = 8'hFF;
    cap_rem   = 4'h0;
    cap_err   = 1'b1;
    cap_we    = 1'b0;
    cap_wdata = 4'h0;
    case (alu_op)
      OP_NOT, OP_AND, OP_NAND, OP_OR, OP_NOR, OP_XOR, OP_XNOR,
      OP_SHIFT, OP_ADD, OP_SUB: begin
        cap_data  = {4'h0, alu_o};
        cap_err   = 1'b0;
        cap_we    = 1'b1;
        cap_wdata = alu_o;
      end
      OP_MUL: begin
        cap_data  = alu_product;
        cap_err   = 1'b0;
        cap_we    = 1'b1;
        cap_wdata = alu_product[3:0];
      end
      OP_DIV: begin
        if (!(DIV0_TRAP && (alu_y == 4'h0))) begin
          cap_data  = {4'h0, alu_o};
          cap_rem   = alu_remainder;
          cap_err   = 1'b0;
          cap_we    = 1'b1;
          cap_wdata = alu_o;
        end
      end
      OP_LOADI: begin
        cap_data  = {4'h0, imm_q};
        cap_err   = 1'b0;
        cap_we    = 1'b1;
        cap_wdata = imm_q;
      end
      default: ;
    endcase
  end

  // ---------------- operand issue ----------------
  // Operands are read at accept, so a later write to the same register cannot disturb them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_x <= 4'h0;
      alu_y <= 4'h0;
      alu_op <= 4'h0;
      rd_q  <= 2'd0;
      imm_q <= 4'h0;
    end else if (accept) begin
      alu_x  <= rf[f_rs];
      alu_y  <= rf[f_rt];
      alu_op <= f_op;
      rd_q   <= f_rd;
      imm_q  <= f_imm;
    end
  end

  // NOTE: the register file is only four entries and must read as zero after reset, so it is reset like any flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'h0;
    end else if ((state == ISSUE) && cap_we) begin
      rf[rd_q] <= cap_wdata;
    end
  end

  // ---------------- result port ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_rem   <= 4'h0;
      out_err   <= 1'b0;
    end else if (state == ISSUE) begin
      out_valid <= 1'b1;
      out_data  <= cap_data;
      out_rem   <= cap_rem;
      out_err   <= cap_err;
    end else if ((state == OUT) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural ALU, instruction-level reference model, directed and random phases.
// Build with ALU_SEQ_DIV0_TRAP_EN defined to check the divide-by-zero trap expectations.
module tb_alu_seq;

`ifdef ALU_SEQ_DIV0_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [3:0]  alu_x, alu_y, alu_op;
  logic [3:0]  alu_o;
  logic [7:0]  alu_product;
  logic [3:0]  alu_remainder;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_rem;
  logic        out_err;

  int checks   = 0;
  int failures = 0;
  bit rdy_auto = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic [3:0] rem;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] m_rf [4];

  alu_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_o(alu_o),
    .alu_product(alu_product), .alu_remainder(alu_remainder),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rem(out_rem), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {o, remainder, product}.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
    logic [3:0] o, r;
    logic [7:0] p;
    p = 8'(x) * 8'(y);
    r = 4'h0;
    case (op)
      4'd0:  o = ~x;
      4'd1:  o = x & y;
      4'd2:  o = ~(x & y);
      4'd3:  o = x | y;
      4'd4:  o = ~(x | y);
      4'd5:  o = x ^ y;
      4'd6:  o = ~(x ^ y);
      4'd7:  o = x << y[1:0];
      4'd8:  o = x + y;
      4'd9:  o = x - y;
      4'd10: o = p[3:0];
      4'd11: begin
        if (y == 4'h0) begin o = 4'hF; r = x; end
        else begin o = x / y; r = x % y; end
      end
      default: o = 4'h0;
    endcase
    return {o, r, p};
  endfunction

  always_comb begin
    logic [15:0] res;
    res           = alu_fn(alu_op, alu_x, alu_y);
    alu_o         = res[15:12];
    alu_remainder = res[11:8];
    alu_product   = res[7:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: what the result and register file must be after this instruction.
  task automatic model_accept(input logic [15:0] ins);
    logic [3:0]  op, x, y, imm;
    logic [1:0]  rd;
    logic [15:0] a;
    exp_t        e;
    op  = ins[15:12];
    rd  = ins[11:10];
    x   = m_rf[ins[9:8]];
    y   = m_rf[ins[7:6]];
    imm = ins[3:0];
    a   = alu_fn(op, x, y);
    e.data = 8'hFF; e.rem = 4'h0; e.err = 1'b1;
    if (op <= 4'd9) begin
      e.data = {4'h0, a[15:12]}; e.err = 1'b0; m_rf[rd] = a[15:12];
    end else if (op == 4'd10) begin
      e.data = 8'(x) * 8'(y); e.err = 1'b0; m_rf[rd] = e.data[3:0];
    end else if (op == 4'd11) begin
      if (!(TRAP && y == 4'h0)) begin
        e.data = {4'h0, a[15:12]}; e.rem = a[11:8]; e.err = 1'b0; m_rf[rd] = a[15:12];
      end
    end else if (op == 4'd12) begin
      e.data = {4'h0, imm}; e.err = 1'b0; m_rf[rd] = imm;
    end
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [15:0] ins);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++; failures++;
        $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    model_accept(ins);
    in_valid = 1'b0;
    in_instr = 16'($urandom);
  endtask

  // Directed result check with literal expectations; out_ready is assumed high.
  task automatic wait_result(input string name, input logic [7:0] d, input logic [3:0] r, input logic e);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 20) begin
        checks++; failures++;
        $display("FAIL %s_timeout: out_valid stayed 0, required 1", name);
        return;
      end
    end
    check({name, "_data"}, 32'(out_data), 32'(d));
    check({name, "_rem"},  32'(out_rem),  32'(r));
    check({name, "_err"},  32'(out_err),  32'(e));
    @(posedge clk); #1;
  endtask

  // Compare process: every cycle a result is presented it must match the model's oldest entry.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result: out_valid=1 with data %0h, required no result", out_data);
      end else begin
        check("model_data", 32'(out_data), 32'(exp_q[0].data));
        check("model_rem",  32'(out_rem),  32'(exp_q[0].rem));
        check("model_err",  32'(out_err),  32'(exp_q[0].err));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rdy_auto) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_out_data"},  32'(out_data),  32'd0);
    check({name, "_out_rem"},   32'(out_rem),   32'd0);
    check({name, "_out_err"},   32'(out_err),   32'd0);
    check({name, "_alu_x"},     32'(alu_x),     32'd0);
    check({name, "_alu_y"},     32'(alu_y),     32'd0);
    check({name, "_alu_op"},    32'(alu_op),    32'd0);
    check({name, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  task automatic apply_reset_model();
    exp_q.delete();
    for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0; out_ready = 1'b1;
    apply_reset_model();
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_release", 32'(in_ready), 32'd1);

    // LOADI / MUL / ADD wrap
    send(16'hC00F); wait_result("loadi_r0", 8'h0F, 4'h0, 1'b0);
    send(16'hC40F); wait_result("loadi_r1", 8'h0F, 4'h0, 1'b0);
    send(16'hA840); wait_result("mul_r2",   8'hE1, 4'h0, 1'b0);
    send(16'h8E00); wait_result("add_wrap", 8'h00, 4'h0, 1'b0);
    // DIV F/F, then divide by a zero register
    send(16'hBC40); wait_result("div_ff",   8'h01, 4'h0, 1'b0);
    send(16'hC800); wait_result("loadi_r2_zero", 8'h00, 4'h0, 1'b0);
    send(16'hBC80);
    wait_result("div_zero", TRAP ? 8'hFF : 8'h0F, TRAP ? 4'h0 : 4'hF, TRAP);
    send(16'h8B80); wait_result("div_zero_r3_readback", TRAP ? 8'h01 : 8'h0F, 4'h0, 1'b0);
    // illegal opcode 1110 must not write; readback each register as rX = rX + r2(0)
    send(16'hC800); wait_result("loadi_r2_zero2", 8'h00, 4'h0, 1'b0);
    send(16'hE805); wait_result("illegal",  8'hFF, 4'h0, 1'b1);
    send(16'h8A80); wait_result("rb_r2", 8'h00, 4'h0, 1'b0);
    send(16'h8080); wait_result("rb_r0", 8'h0F, 4'h0, 1'b0);
    send(16'h8580); wait_result("rb_r1", 8'h0F, 4'h0, 1'b0);
    send(16'h8F80); wait_result("rb_r3", TRAP ? 8'h01 : 8'h0F, 4'h0, 1'b0);

    // out_ready held low for 5 cycles in OUT
    out_ready = 1'b0;
    send(16'hC407);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_data",  32'(out_data),  32'h07);
      check("hold_in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_in_ready",  32'(in_ready),  32'd1);
    check("hold_release_out_valid", 32'(out_valid), 32'd0);

    // reset pulsed while the instruction sits in ISSUE
    send(16'hC003);
    rst = 1'b1;
    apply_reset_model();
    #1;
    check_reset_outputs("rst_in_issue");
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("aborted_no_result", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(16'h8040); wait_result("aborted_r0_readback", 8'h00, 4'h0, 1'b0);
    send(16'hC809); wait_result("loadi_after_reset",   8'h09, 4'h0, 1'b0);

    // random phase: any opcode, random gaps and back-pressure
    rdy_auto = 1'b1;
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) begin
        in_instr = 16'($urandom);
        @(posedge clk); #1;
      end
      send(16'($urandom));
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
